// File: rtl/tdoa_pkg.sv
// Shared types and constants for the three-microphone TDoA capture path.
package tdoa_pkg;

  localparam int TIME_W = 32;

  localparam logic [1:0] MIC1 = 2'd1;
  localparam logic [1:0] MIC2 = 2'd2;
  localparam logic [1:0] MIC3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ARMED,
    ST_WAIT_ALL,
    ST_LATCH,
    ST_REPORT,
    ST_HOLDOFF
  } state_e;

endpackage

// File: rtl/tdoa_delta_calc.sv
// Combinational time-difference and earliest-mic computation, mic 1 as reference.
module tdoa_delta_calc
  import tdoa_pkg::*;
(
  input  logic [TIME_W-1:0]        t1_i,
  input  logic [TIME_W-1:0]        t2_i,
  input  logic [TIME_W-1:0]        t3_i,
  output logic signed [TIME_W-1:0] dt_21_o,
  output logic signed [TIME_W-1:0] dt_31_o,
  output logic [1:0]               first_mic_o
);

  logic signed [TIME_W-1:0] min_v;

  // Modulo-2^32 differences stay correct across sample-counter wrap; strict
  // less-than in index order makes ties resolve to the lowest mic index.
  always_comb begin
    dt_21_o     = signed'(t2_i - t1_i);
    dt_31_o     = signed'(t3_i - t1_i);
    first_mic_o = MIC1;
    min_v       = '0;
    if (dt_21_o < min_v) begin
      first_mic_o = MIC2;
      min_v       = dt_21_o;
    end
    if (dt_31_o < min_v) begin
      first_mic_o = MIC3;
    end
  end

endmodule

// File: rtl/tdoa_capture_controller.sv
// Sequences clear / arm / capture / report / holdoff cycles for three peak detectors.
// Handshake: result_valid rises with a fresh capture and stays high with stable
// outputs until result_ack is sampled high while valid; ack at any other time is ignored.
module tdoa_capture_controller
  import tdoa_pkg::*;
#(
  parameter int CLEAR_CYCLES = 4,
  parameter int TIMEOUT      = 2000,
  parameter int HOLDOFF      = 4800,
  parameter int CNT_W        = 16
) (
  input  logic                     pcm_clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     peak_triggered_1,
  input  logic                     peak_triggered_2,
  input  logic                     peak_triggered_3,
  input  logic [TIME_W-1:0]        triggered_time_1,
  input  logic [TIME_W-1:0]        triggered_time_2,
  input  logic [TIME_W-1:0]        triggered_time_3,
  output logic                     det_clear,
  output logic                     result_valid,
  input  logic                     result_ack,
  output logic signed [TIME_W-1:0] dt_21,
  output logic signed [TIME_W-1:0] dt_31,
  output logic [1:0]               first_mic,
  output logic                     timeout_flag,
  output logic [CNT_W-1:0]         capture_count,
  output logic [CNT_W-1:0]         abort_count,
  output state_e                   dbg_state
);

  // One shared timer covers the clear, timeout and holdoff intervals.
  localparam int TMR_MAX = (HOLDOFF > TIMEOUT)
                         ? ((HOLDOFF > CLEAR_CYCLES) ? HOLDOFF : CLEAR_CYCLES)
                         : ((TIMEOUT > CLEAR_CYCLES) ? TIMEOUT : CLEAR_CYCLES);
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] CLR_LAST = TMR_W'(CLEAR_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] HO_LAST  = TMR_W'(HOLDOFF - 1);

  state_e                   state_q;
  logic [TMR_W-1:0]         timer_q;
  logic                     det_clear_q;
  logic                     result_valid_q;
  logic signed [TIME_W-1:0] dt_21_q;
  logic signed [TIME_W-1:0] dt_31_q;
  logic [1:0]               first_mic_q;
  logic                     timeout_flag_q;
  logic [CNT_W-1:0]         capture_count_q;
  logic [CNT_W-1:0]         abort_count_q;

  logic                     any_trig;
  logic                     all_trig;
  logic signed [TIME_W-1:0] calc_dt_21;
  logic signed [TIME_W-1:0] calc_dt_31;
  logic [1:0]               calc_first;

  assign any_trig = peak_triggered_1 | peak_triggered_2 | peak_triggered_3;
  assign all_trig = peak_triggered_1 & peak_triggered_2 & peak_triggered_3;

  tdoa_delta_calc u_delta_calc (
    .t1_i        (triggered_time_1),
    .t2_i        (triggered_time_2),
    .t3_i        (triggered_time_3),
    .dt_21_o     (calc_dt_21),
    .dt_31_o     (calc_dt_31),
    .first_mic_o (calc_first)
  );

  // Capture sequencer: all outputs are registered alongside the state.
  always_ff @(posedge pcm_clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      timer_q         <= '0;
      det_clear_q     <= 1'b1;
      result_valid_q  <= 1'b0;
      dt_21_q         <= '0;
      dt_31_q         <= '0;
      first_mic_q     <= 2'd0;
      timeout_flag_q  <= 1'b0;
      capture_count_q <= '0;
      abort_count_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          det_clear_q <= 1'b1;
          if (enable) begin
            state_q <= ST_CLEAR;
            timer_q <= CLR_LAST;
          end
        end
        ST_CLEAR: begin
          if (timer_q == '0) begin
            state_q     <= ST_ARMED;
            det_clear_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        ST_ARMED: begin
          if (all_trig) begin
            state_q <= ST_LATCH;
          end else if (any_trig) begin
            state_q <= ST_WAIT_ALL;
            timer_q <= '0;
          end else if (!enable) begin
            state_q     <= ST_IDLE;
            det_clear_q <= 1'b1;
          end
        end
        ST_WAIT_ALL: begin
          // A completing trigger beats a coincident timeout expiry.
          if (all_trig) begin
            state_q <= ST_LATCH;
          end else if (!enable) begin
            state_q     <= ST_IDLE;
            det_clear_q <= 1'b1;
          end else if (timer_q == TO_LAST) begin
            state_q        <= ST_HOLDOFF;
            timer_q        <= HO_LAST;
            det_clear_q    <= 1'b1;
            timeout_flag_q <= 1'b1;
            abort_count_q  <= abort_count_q + 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_LATCH: begin
          state_q         <= ST_REPORT;
          dt_21_q         <= calc_dt_21;
          dt_31_q         <= calc_dt_31;
          first_mic_q     <= calc_first;
          capture_count_q <= capture_count_q + 1'b1;
          timeout_flag_q  <= 1'b0;
          result_valid_q  <= 1'b1;
        end
        ST_REPORT: begin
          if (result_ack && result_valid_q) begin
            state_q        <= ST_HOLDOFF;
            timer_q        <= HO_LAST;
            result_valid_q <= 1'b0;
            det_clear_q    <= 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (timer_q == '0) begin
            if (enable) begin
              state_q <= ST_CLEAR;
              timer_q <= CLR_LAST;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          det_clear_q <= 1'b1;
        end
      endcase
    end
  end

  assign det_clear     = det_clear_q;
  assign result_valid  = result_valid_q;
  assign dt_21         = dt_21_q;
  assign dt_31         = dt_31_q;
  assign first_mic     = first_mic_q;
  assign timeout_flag  = timeout_flag_q;
  assign capture_count = capture_count_q;
  assign abort_count   = abort_count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_tdoa_capture_controller.sv
// Directed bench for the TDoA capture controller.
module tb_tdoa_capture_controller;
  import tdoa_pkg::*;

  localparam int CLEAR_CYCLES = 4;
  localparam int TIMEOUT      = 2000;
  localparam int HOLDOFF      = 4800;
  localparam int CNT_W        = 16;

  logic             pcm_clk;
  logic             reset;
  logic             enable;
  logic             pt1, pt2, pt3;
  logic [31:0]      tt1, tt2, tt3;
  logic             det_clear;
  logic             result_valid;
  logic             result_ack;
  logic [31:0]      dt_21, dt_31;
  logic [1:0]       first_mic;
  logic             timeout_flag;
  logic [CNT_W-1:0] capture_count, abort_count;
  state_e           dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [65:0] exp_q[$];

  tdoa_capture_controller #(
    .CLEAR_CYCLES (CLEAR_CYCLES),
    .TIMEOUT      (TIMEOUT),
    .HOLDOFF      (HOLDOFF),
    .CNT_W        (CNT_W)
  ) dut (
    .pcm_clk          (pcm_clk),
    .reset            (reset),
    .enable           (enable),
    .peak_triggered_1 (pt1),
    .peak_triggered_2 (pt2),
    .peak_triggered_3 (pt3),
    .triggered_time_1 (tt1),
    .triggered_time_2 (tt2),
    .triggered_time_3 (tt3),
    .det_clear        (det_clear),
    .result_valid     (result_valid),
    .result_ack       (result_ack),
    .dt_21            (dt_21),
    .dt_31            (dt_31),
    .first_mic        (first_mic),
    .timeout_flag     (timeout_flag),
    .capture_count    (capture_count),
    .abort_count      (abort_count),
    .dbg_state        (dbg_state)
  );

  // Clock
  initial pcm_clk = 1'b0;
  always #5 pcm_clk = ~pcm_clk;

  task automatic tick;
    @(posedge pcm_clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_result(input logic [31:0] e21, input logic [31:0] e31, input logic [1:0] efm);
    exp_q.push_back({e21, e31, efm});
  endtask

  task automatic check_result(input string tag);
    logic [65:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_valid"}, result_valid, 1);
      check_val({tag, "_dt21"}, dt_21, e[65:34]);
      check_val({tag, "_dt31"}, dt_31, e[33:2]);
      check_val({tag, "_first"}, first_mic, e[1:0]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_state"}, dbg_state, ST_IDLE);
    check_val({tag, "_detclr"}, det_clear, 1);
    check_val({tag, "_valid"}, result_valid, 0);
    check_val({tag, "_dt21"}, dt_21, 0);
    check_val({tag, "_dt31"}, dt_31, 0);
    check_val({tag, "_first"}, first_mic, 0);
    check_val({tag, "_tflag"}, timeout_flag, 0);
    check_val({tag, "_capcnt"}, capture_count, 0);
    check_val({tag, "_abtcnt"}, abort_count, 0);
  endtask

  task automatic wait_armed(input string tag);
    int n = 0;
    while (dbg_state != ST_ARMED && n < 10000) begin
      tick;
      n++;
    end
    check_val({tag, "_armed"}, dbg_state, ST_ARMED);
  endtask

  // Called right after the edge that entered HOLDOFF.
  task automatic wait_holdoff(input string tag);
    int n = 0;
    bit dc_ok = 1'b1;
    while (dbg_state == ST_HOLDOFF && n < 6000) begin
      if (!det_clear) dc_ok = 1'b0;
      tick;
      n++;
    end
    check_val({tag, "_ho_len"}, n, HOLDOFF);
    check_val({tag, "_ho_detclr"}, dc_ok, 1);
  endtask

  task automatic set_trig(input logic f1, input logic f2, input logic f3);
    pt1 = f1;
    pt2 = f2;
    pt3 = f3;
  endtask

  task automatic set_times(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    tt1 = a;
    tt2 = b;
    tt3 = c;
  endtask

  task automatic ack_and_clear;
    result_ack = 1'b1;
    set_trig(0, 0, 0);
    tick;
    result_ack = 1'b0;
  endtask

  initial begin
    int  n;
    bit  ok;
    logic [31:0] s21, s31;

    reset = 1'b1;
    enable = 1'b0;
    result_ack = 1'b0;
    set_trig(0, 0, 0);
    set_times(0, 0, 0);
    repeat (3) tick;
    check_reset_vals("por");
    reset = 1'b0;
    tick;

    // Ack in IDLE is ignored
    result_ack = 1'b1;
    tick;
    result_ack = 1'b0;
    tick;
    check_val("idle_ack_state", dbg_state, ST_IDLE);
    check_val("idle_ack_valid", result_valid, 0);

    // Clear phase length
    enable = 1'b1;
    tick;
    check_val("clear_entry", dbg_state, ST_CLEAR);
    n = 0;
    while (det_clear && n < 20) begin
      tick;
      n++;
    end
    check_val("clear_len", n, CLEAR_CYCLES);
    check_val("clear_to_armed", dbg_state, ST_ARMED);

    // Ack in ARMED is ignored
    result_ack = 1'b1;
    tick;
    result_ack = 1'b0;
    tick;
    check_val("armed_ack_state", dbg_state, ST_ARMED);
    check_val("armed_ack_valid", result_valid, 0);

    // Basic capture: t3 earliest
    set_times(32'd1000, 32'd1012, 32'd995);
    expect_result(32'd12, -32'sd5, 2'd3);
    set_trig(1, 1, 1);
    tick;
    check_val("cap1_lat_valid", result_valid, 0);
    tick;
    check_result("cap1");
    check_val("cap1_capcnt", capture_count, 1);
    check_val("cap1_tflag", timeout_flag, 0);

    // Hold off ack, toggle enable: outputs must stay put
    s21 = dt_21;
    s31 = dt_31;
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) enable = 1'b0;
      if (i == 40) enable = 1'b1;
      tick;
      if (!result_valid || dt_21 !== s21 || dt_31 !== s31 || first_mic !== 2'd3) ok = 1'b0;
    end
    check_val("report_stable", ok, 1);
    check_val("report_state", dbg_state, ST_REPORT);
    ack_and_clear;
    check_val("ack_valid_low", result_valid, 0);
    check_val("ack_to_holdoff", dbg_state, ST_HOLDOFF);
    wait_holdoff("ho1");
    wait_armed("rearm1");

    // Lone mic 1 -> abort exactly at timeout
    set_trig(1, 0, 0);
    tick;
    check_val("to_wait", dbg_state, ST_WAIT_ALL);
    ok = 1'b1;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick;
      if (result_valid) ok = 1'b0;
    end
    check_val("to_no_valid", ok, 1);
    check_val("to_before_flag", timeout_flag, 0);
    tick;
    check_val("to_flag", timeout_flag, 1);
    check_val("to_abtcnt", abort_count, 1);
    check_val("to_state", dbg_state, ST_HOLDOFF);
    check_val("to_capcnt", capture_count, 1);
    set_trig(0, 0, 0);
    wait_holdoff("ho2");
    wait_armed("rearm2");

    // Mic 3 arrives on the expiry cycle; also counter-wrap arithmetic
    set_times(32'hFFFF_FFF0, 32'h0000_0010, 32'hFFFF_FFE0);
    expect_result(32'd32, -32'sd16, 2'd3);
    set_trig(1, 1, 0);
    tick;
    repeat (TIMEOUT - 1) tick;
    set_trig(1, 1, 1);
    tick;
    check_val("exp_latch", dbg_state, ST_LATCH);
    tick;
    check_result("cap2");
    check_val("cap2_abtcnt", abort_count, 1);
    check_val("cap2_capcnt", capture_count, 2);
    check_val("cap2_tflag", timeout_flag, 0);
    ack_and_clear;
    wait_holdoff("ho3");
    wait_armed("rearm3");

    // Equal times: mic 1 wins the tie
    set_times(32'h1234, 32'h1234, 32'h1234);
    expect_result(32'd0, 32'd0, 2'd1);
    set_trig(1, 1, 1);
    tick;
    tick;
    check_result("cap3");
    ack_and_clear;
    wait_holdoff("ho4");
    wait_armed("rearm4");

    // Async reset mid-WAIT_ALL
    set_trig(1, 0, 0);
    tick;
    repeat (10) tick;
    check_val("rst_w_pre", dbg_state, ST_WAIT_ALL);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("rst_wait");
    set_trig(0, 0, 0);
    tick;
    reset = 1'b0;
    wait_armed("rearm5");

    // Async reset mid-REPORT
    set_times(32'd50, 32'd40, 32'd60);
    set_trig(1, 1, 1);
    tick;
    tick;
    check_val("rst_r_pre", result_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("rst_report");
    set_trig(0, 0, 0);
    tick;
    reset = 1'b0;
    wait_armed("rearm6");

    // enable low in ARMED -> IDLE
    enable = 1'b0;
    tick;
    check_val("dis_armed_state", dbg_state, ST_IDLE);
    check_val("dis_armed_detclr", det_clear, 1);

    // enable low in WAIT_ALL -> IDLE without abort
    enable = 1'b1;
    wait_armed("rearm7");
    set_trig(1, 0, 0);
    tick;
    repeat (5) tick;
    enable = 1'b0;
    tick;
    check_val("dis_wait_state", dbg_state, ST_IDLE);
    check_val("dis_wait_abtcnt", abort_count, 0);
    check_val("dis_wait_tflag", timeout_flag, 0);
    set_trig(0, 0, 0);

    check_val("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
